spi_flash_emu_slave: RTL

//  Synthesizable SPI-NOR flash responder: the far end of the flash command master. Decodes

---
 rtl/spi_flash_emu_if.sv | 28 ++
 rtl/spi_flash_emu_slave.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_emu_if.sv
// SPI pin bundle between a flash command master and the flash emulator.
// The slave modport is the flash side; the master modport is the controller side.
interface spi_flash_emu_if;
  logic i_spi_cs;
  logic i_spi_clk;
  logic i_spi_mosi;
  logic o_spi_miso;
  logic o_wel;
  logic o_wip;

  modport slave (
    input  i_spi_cs,
    input  i_spi_clk,
    input  i_spi_mosi,
    output o_spi_miso,
    output o_wel,
    output o_wip
  );

  modport master (
    output i_spi_cs,
    output i_spi_clk,
    output i_spi_mosi,
    input  o_spi_miso,
    input  o_wel,
    input  o_wip
  );
endinterface

// File: rtl/spi_flash_emu_slave.sv
// SPI-NOR flash responder (mode 0): WREN/PP/READ/SE/RDSR over an internal RAM with WEL/WIP emulation.
// Define FLASH_EMU_PROG_AND_EN for NOR program semantics (RAM &= data); otherwise program overwrites.
module spi_flash_emu_slave #(
  parameter int P_MEM_DEPTH    = 8192,
  parameter int P_PROG_CYCLES  = 512,
  parameter int P_ERASE_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  spi_flash_emu_if.slave if_spi
);
  localparam int AW   = $clog2(P_MEM_DEPTH);
  localparam int MAXC = (P_ERASE_CYCLES > P_PROG_CYCLES) ? P_ERASE_CYCLES : P_PROG_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {F_IDLE, F_CMD, F_ADDR, F_RD, F_STAT, F_WR, F_EWAIT, F_IGN} frame_t;
  typedef enum logic [1:0] {O_IDLE, O_ERASE, O_WAIT} op_t;

  logic [1:0]    r_cs_s, r_sck_s, r_mosi_s;
  logic          r_cs_d, r_sck_d;
  frame_t        r_fst;
  op_t           r_ost;
  logic [2:0]    r_bitcnt, r_obit;
  logic [1:0]    r_acnt;
  logic [6:0]    r_sin;
  logic [7:0]    r_opc, r_sout, r_rdata;
  logic [23:0]   r_addr;
  logic [23:12]  r_ebase;
  logic          r_wel, r_oen, r_wr_any, r_ew_extra;
  logic [11:0]   r_ecnt;
  logic [CW-1:0] r_wcnt;
  logic [7:0]    r_mem [P_MEM_DEPTH];

  logic          w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall, w_mosi, w_wip;
  logic          w_wr_we, w_we, w_prog_go, w_erase_go;
  logic [7:0]    w_byte, w_wr_data, w_wdata;
  logic [AW-1:0] w_waddr, w_eaddr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cs_s   <= 2'b11;
      r_sck_s  <= 2'b00;
      r_mosi_s <= 2'b00;
      r_cs_d   <= 1'b1;
      r_sck_d  <= 1'b0;
    end else begin
      r_cs_s   <= {r_cs_s[0], if_spi.i_spi_cs};
      r_sck_s  <= {r_sck_s[0], if_spi.i_spi_clk};
      r_mosi_s <= {r_mosi_s[0], if_spi.i_spi_mosi};
      r_cs_d   <= r_cs_s[1];
      r_sck_d  <= r_sck_s[1];
    end
  end

  assign w_cs_fall  = r_cs_d & ~r_cs_s[1];
  assign w_cs_rise  = ~r_cs_d & r_cs_s[1];
  assign w_sck_rise = ~r_sck_d & r_sck_s[1];
  assign w_sck_fall = r_sck_d & ~r_sck_s[1];
  assign w_mosi     = r_mosi_s[1];
  assign w_byte     = {r_sin, w_mosi};
  assign w_wip      = (r_ost != O_IDLE);

  // Commit decisions are taken on the CS rise that closes a program or erase frame.
  assign w_prog_go  = w_cs_rise & (r_fst == F_WR) & r_wr_any;
  assign w_erase_go = w_cs_rise & (r_fst == F_EWAIT) & ~r_ew_extra;
  assign w_wr_we    = ~w_cs_rise & ~w_cs_fall & w_sck_rise & (r_bitcnt == 3'd7) & (r_fst == F_WR);

`ifdef FLASH_EMU_PROG_AND_EN
  assign w_wr_data = r_rdata & w_byte;
`else
  assign w_wr_data = w_byte;
`endif

  assign w_eaddr = AW'({r_ebase, r_ecnt});
  assign w_we    = (r_ost == O_ERASE) | w_wr_we;
  assign w_waddr = (r_ost == O_ERASE) ? w_eaddr : r_addr[AW-1:0];
  assign w_wdata = (r_ost == O_ERASE) ? 8'hFF : w_wr_data;

  // r_rdata continuously tracks RAM[r_addr]; it doubles as read prefetch and program read-back.
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_rdata <= r_mem[r_addr[AW-1:0]];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fst      <= F_IDLE;
      r_bitcnt   <= '0;
      r_obit     <= '0;
      r_acnt     <= '0;
      r_sin      <= '0;
      r_opc      <= '0;
      r_sout     <= '0;
      r_addr     <= '0;
      r_wel      <= 1'b0;
      r_oen      <= 1'b0;
      r_wr_any   <= 1'b0;
      r_ew_extra <= 1'b0;
    end else if (w_cs_rise) begin
      r_fst <= F_IDLE;
      r_oen <= 1'b0;
      if (w_prog_go || w_erase_go) r_wel <= 1'b0;
    end else if (w_cs_fall) begin
      r_fst      <= F_CMD;
      r_bitcnt   <= '0;
      r_obit     <= '0;
      r_acnt     <= '0;
      r_oen      <= 1'b0;
      r_wr_any   <= 1'b0;
      r_ew_extra <= 1'b0;
    end else begin
      if (w_sck_rise) begin
        r_sin    <= w_byte[6:0];
        r_bitcnt <= r_bitcnt + 3'd1;
        case (r_fst)
          F_CMD: begin
            if (r_bitcnt == 3'd7) begin
              r_opc <= w_byte;
              if (w_byte == 8'h05) r_fst <= F_STAT;
              else if (w_wip) r_fst <= F_IGN;
              else begin
                case (w_byte)
                  8'h06: begin
                    r_wel <= 1'b1;
                    r_fst <= F_IGN;
                  end
                  8'h02, 8'h03, 8'h20: r_fst <= F_ADDR;
                  default: r_fst <= F_IGN;
                endcase
              end
            end
          end
          F_ADDR: begin
            r_addr <= {r_addr[22:0], w_mosi};
            if (r_bitcnt == 3'd7) begin
              r_acnt <= r_acnt + 2'd1;
              if (r_acnt == 2'd2) begin
                case (r_opc)
                  8'h03:   r_fst <= F_RD;
                  8'h02:   r_fst <= r_wel ? F_WR : F_IGN;
                  8'h20:   r_fst <= r_wel ? F_EWAIT : F_IGN;
                  default: r_fst <= F_IGN;
                endcase
              end
            end
          end
          F_WR: begin
            // Page program: only the low address byte advances.
            if (r_bitcnt == 3'd7) begin
              r_wr_any    <= 1'b1;
              r_addr[7:0] <= r_addr[7:0] + 8'd1;
            end
          end
          F_EWAIT: r_ew_extra <= 1'b1;
          default: ;
        endcase
      end
      if (w_sck_fall && (r_fst == F_RD || r_fst == F_STAT)) begin
        r_obit <= r_obit + 3'd1;
        if (r_obit == 3'd0) begin
          r_oen <= 1'b1;
          if (r_fst == F_RD) begin
            r_sout <= r_rdata;
            r_addr <= r_addr + 24'd1;
          end else begin
            r_sout <= {6'b0, r_wel, w_wip};
          end
        end else begin
          r_sout <= {r_sout[6:0], 1'b0};
        end
      end
    end
  end

  // Erase walks the whole 4 KiB sector one byte per cycle, then both ops share the busy countdown.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ost   <= O_IDLE;
      r_ecnt  <= '0;
      r_ebase <= '0;
      r_wcnt  <= '0;
    end else begin
      case (r_ost)
        O_IDLE: begin
          if (w_erase_go) begin
            r_ost   <= O_ERASE;
            r_ecnt  <= '0;
            r_ebase <= r_addr[23:12];
          end else if (w_prog_go) begin
            r_ost  <= O_WAIT;
            r_wcnt <= CW'(P_PROG_CYCLES - 1);
          end
        end
        O_ERASE: begin
          r_ecnt <= r_ecnt + 12'd1;
          if (r_ecnt == 12'hFFF) begin
            r_ost  <= O_WAIT;
            r_wcnt <= CW'(P_ERASE_CYCLES - 1);
          end
        end
        O_WAIT: begin
          if (r_wcnt == '0) r_ost <= O_IDLE;
          else r_wcnt <= r_wcnt - 1'b1;
        end
        default: r_ost <= O_IDLE;
      endcase
    end
  end

  assign if_spi.o_spi_miso = r_oen & r_sout[7];
  assign if_spi.o_wel      = r_wel;
  assign if_spi.o_wip      = w_wip;
endmodule
